wb_stage: RTL
=============

# wb_stage

MEM/WB pipeline register and write-back stage of the 64-bit RISC-V pipeline. Captures the instruction leaving MEM, extracts and extends load data from the raw 64-bit memory doubleword, and selects the write-back value. It drives the register file write port (`we`, `write_addr`, `write_data`) and keeps a retired-instruction counter. `write_data` also serves as the WB-stage forwarding source for EX.

## Interface
- `XLEN`, 64, datapath width; only 64 is supported.

- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hold WB register contents.
- `flush`  in  1  load a bubble into WB.
- `mem_valid`  in  1  MEM-stage instruction is valid.
- `mem_pc`  in  64  PC of MEM-stage instruction.
- `mem_rd`  in  5  destination register.
- `mem_reg_we`  in  1  instruction writes rd.
- `mem_wb_sel`  in  2  00 ALU result, 01 load data, 10 PC+4, 11 immediate (LUI).
- `mem_alu_res`  in  64  ALU result; also the load address.
- `mem_imm`  in  64  immediate.
- `mem_funct3`  in  3  load width/sign.
- `mem_rdata`  in  64  raw aligned doubleword from data memory.
- `wb_valid`  out  1  WB holds a valid instruction.
- `wb_pc`  out  64  PC of WB instruction.
- `we`  out  1  register file write enable.
- `write_addr`  out  5  register file write address.
- `write_data`  out  64  register file write data / forwarding data.
- `wb_load_fault`  out  1  WB instruction is a faulting load.
- `instret`  out  64  retired-instruction count.

## Operation
- **Byte offset:** `off = mem_alu_res[2:0]`.
- **Load extraction (`mem_wb_sel == 01`):**
  - funct3 000 `lb`: byte `mem_rdata[8*off +: 8]`, sign-extended. 100 `lbu`: same byte, zero-extended.
  - 001 `lh` / 101 `lhu`: half at `off`, sign-/zero-extended; requires `off[0] == 0`.
  - 010 `lw` / 110 `lwu`: word at `off`, sign-/zero-extended; requires `off[1:0] == 0`.
  - 011 `ld`: full doubleword; requires `off == 0`.
  - 111: illegal.
  - Alignment violation or illegal funct3 sets the fault.
- **Other selects:**
  - 00: `mem_alu_res`.
  - 10: `mem_pc + 4`, modulo 2^64 (wraps).
  - 11: `mem_imm`.
- **Fault rule:** the fault flag is only meaningful when `mem_wb_sel == 01`; otherwise it is 0.
- **Capture priority** (rising edge, `rst` low): `flush` > `stall` > normal.
  - `flush`: `wb_valid` ← 0, `we` ← 0, `wb_load_fault` ← 0. Other fields are don't-care.
  - `stall`: every register holds, including `instret`.
  - Normal: `wb_valid` ← `mem_valid`, `wb_pc` ← `mem_pc`, `write_addr` ← `mem_rd`, `write_data` ← selected value, `wb_load_fault` ← `mem_valid & fault`.
- **Write enable:** `we` ← `mem_valid & mem_reg_we & (mem_rd != 0) & !fault`. A faulting load never writes; `write_data` for a faulting load is 0.
- **instret:** increments by 1 on every normal capture with `mem_valid = 1`, including faulting loads. It is not incremented on flush or stall. It wraps from all-ones to 0.
- **Reset:** all outputs and internal registers are 0 (`wb_valid`, `wb_pc`, `we`, `write_addr`, `write_data`, `wb_load_fault`, `instret`).

## Timing
- All outputs are registered; latency is 1 cycle from MEM inputs to WB outputs.
- The register file writes on the falling edge. `we`, `write_addr` and `write_data` are stable from the rising edge, so the write completes mid-cycle of the same cycle. A read of the same register by ID in that cycle returns the new value.
- During `stall`, outputs hold and the register file rewrites the same value each cycle. This is idempotent and permitted.
- `rst` asserted mid-operation clears outputs immediately, without waiting for a clock edge. The first capture occurs at the first rising edge after `rst` deasserts.
- Simultaneous `flush` and `stall`: flush wins, producing a bubble.
- No combinational path from any input to any output.

## Test plan
- **Reset:** assert `rst` asynchronously between edges with `instret = 5` and `we = 1` → all outputs 0 immediately; first valid capture after release gives `instret = 1`.
- **ALU write:** `mem_valid = 1`, `mem_reg_we = 1`, `rd = 5`, `sel = 00`, `alu_res = 0x1234` → next cycle `we = 1`, `write_addr = 5`, `write_data = 0x1234`. `rd = 0` with the same inputs → `we = 0`.
- **Load extraction:** `rdata = 0x8877_6655_4433_2211`, all with `sel = 01`:

  | Load | `off` | Expected `write_data` |
  |---|---|---|
  | `lb` | 7 | `0xFFFF_FFFF_FFFF_FF88` |
  | `lbu` | 7 | `0x88` |
  | `lh` | 6 | `0xFFFF_FFFF_FFFF_8877` |
  | `lwu` | 4 | `0x8877_6655` |
  | `ld` | 0 | full value |

- **Faults:** `lw` with `off = 2`, or funct3 111 → `wb_load_fault = 1`, `we = 0`, `write_data = 0`, `instret` incremented.
- **Flush/stall:** three valid instructions with `stall` on the 2nd capture → outputs hold one extra cycle and `instret` ends at 3. Same sequence with `flush` and `stall` together on the 2nd capture → bubble (`wb_valid = 0`) and `instret` ends at 2.
- **PC+4 and wrap:** `sel = 10`, `pc = 0xFFFF_FFFF_FFFF_FFFC` → `write_data = 0`. Preload `instret` to all-ones via a sequence, then one valid capture → `instret = 0`.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with load extraction, write-back select and instret counter
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            mem_valid_i,
    input  logic [XLEN-1:0] mem_pc_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_reg_we_i,
    input  logic [1:0]      mem_wb_sel_i,
    input  logic [XLEN-1:0] mem_alu_res_i,
    input  logic [XLEN-1:0] mem_imm_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_pc_o,
    output logic            we_o,
    output logic [4:0]      write_addr_o,
    output logic [XLEN-1:0] write_data_o,
    output logic            wb_load_fault_o,
    output logic [XLEN-1:0] instret_o
);
    logic [2:0]      off;
    logic [XLEN-1:0] sh, ld_val, sel_val;
    logic            mis, fault;
    logic            valid_q, valid_d, we_q, we_d, fault_q, fault_d;
    logic [XLEN-1:0] pc_q, pc_d, data_q, data_d, instret_q, instret_d;
    logic [4:0]      addr_q, addr_d;

    always_comb begin
        off = mem_alu_res_i[2:0];
        sh = mem_rdata_i >> {off, 3'b000};
        ld_val = '0;
        mis = 1'b0;
        case (mem_funct3_i)
            3'b000: ld_val = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b100: ld_val = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b001: begin ld_val = {{(XLEN-16){sh[15]}}, sh[15:0]}; mis = off[0]; end
            3'b101: begin ld_val = {{(XLEN-16){1'b0}}, sh[15:0]}; mis = off[0]; end
            3'b010: begin ld_val = {{(XLEN-32){sh[31]}}, sh[31:0]}; mis = |off[1:0]; end
            3'b110: begin ld_val = {{(XLEN-32){1'b0}}, sh[31:0]}; mis = |off[1:0]; end
            3'b011: begin ld_val = sh; mis = |off; end
            default: mis = 1'b1;
        endcase
        fault = (mem_wb_sel_i == 2'b01) & mis;
        sel_val = mem_wb_sel_i == 2'b00 ? mem_alu_res_i :
                  mem_wb_sel_i == 2'b01 ? (fault ? '0 : ld_val) :
                  mem_wb_sel_i == 2'b10 ? mem_pc_i + XLEN'(4) : mem_imm_i;
    end

    // flush beats stall; flush leaves pc/addr/data/instret untouched
    always_comb begin
        valid_d = valid_q;
        we_d = we_q;
        fault_d = fault_q;
        pc_d = pc_q;
        addr_d = addr_q;
        data_d = data_q;
        instret_d = instret_q;
        if (flush_i) begin
            valid_d = 1'b0;
            we_d = 1'b0;
            fault_d = 1'b0;
        end else if (!stall_i) begin
            valid_d = mem_valid_i;
            we_d = mem_valid_i & mem_reg_we_i & (mem_rd_i != 5'd0) & !fault;
            fault_d = mem_valid_i & fault;
            pc_d = mem_pc_i;
            addr_d = mem_rd_i;
            data_d = sel_val;
            instret_d = instret_q + XLEN'(mem_valid_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q <= 1'b0;
            fault_q <= 1'b0;
            pc_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            instret_q <= '0;
        end else begin
            valid_q <= valid_d;
            we_q <= we_d;
            fault_q <= fault_d;
            pc_q <= pc_d;
            addr_q <= addr_d;
            data_q <= data_d;
            instret_q <= instret_d;
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_pc_o = pc_q;
    assign we_o = we_q;
    assign write_addr_o = addr_q;
    assign write_data_o = data_q;
    assign wb_load_fault_o = fault_q;
    assign instret_o = instret_q;
endmodule
